// File: rtl/estacionamiento_multicanal_if.sv
// Sensor pins and occupancy/event outputs of the multi-lane parking counter.
// master drives the barrier pins; slave is the counter itself.
interface estacionamiento_multicanal_if #(
  parameter int N_LANES = 2,
  parameter int CNT_W   = 3
);
  logic [N_LANES-1:0] a;
  logic [N_LANES-1:0] b;
  logic [CNT_W-1:0]   cantidad;
  logic               lleno;
  logic               vacio;
  logic [N_LANES-1:0] entrada_p;
  logic [N_LANES-1:0] salida_p;
  logic [N_LANES-1:0] error_seq;
  logic               desborde;

  modport master (
    output a, b,
    input  cantidad, lleno, vacio, entrada_p, salida_p, error_seq, desborde
  );

  modport slave (
    input  a, b,
    output cantidad, lleno, vacio, entrada_p, salida_p, error_seq, desborde
  );
endinterface

// File: rtl/estacionamiento_multicanal.sv
// Multi-lane parking occupancy counter: sync + debounce + direction FSM per lane, shared clamped counter.
// Pin-to-filtered 2+DEB_CYCLES cycles, events one cycle later; no backpressure (sensors are free-running).
module estacionamiento_multicanal #(
  parameter int N_LANES    = 2,
  parameter int CAPACITY   = 7,
  parameter int CNT_W      = 3,
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  estacionamiento_multicanal_if.slave bus
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int SW = CNT_W + $clog2(N_LANES) + 1;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);
  localparam logic signed [SW-1:0] UNO   = SW'(1);

  typedef enum logic [2:0] {
    REPOSO, E1, E2, E3, S1, S2, S3, INVALIDO
  } estado_t;

  logic [N_LANES-1:0] ent_c;
  logic [N_LANES-1:0] sal_c;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    // index 0 = outer (a), index 1 = inner (b); levels are active-high after inversion
    logic [1:0]    raw;
    logic [1:0]    sy1;
    logic [1:0]    sy2;
    logic [1:0]    filt;
    logic [DW-1:0] deb [2];
    logic          fa;
    logic          fb;
    logic [1:0]    p;
    logic [1:0]    q;
    estado_t       st;
    estado_t       st_d;
    logic          ent_r;
    logic          sal_r;
    logic          err_r;

    assign raw = {~bus.b[i], ~bus.a[i]};
    assign fa  = filt[0];
    assign fb  = filt[1];
    assign p   = {fa, fb};
    assign q   = {fb, fa};

    always_ff @(posedge clk) begin
      if (reset) begin
        sy1  <= '0;
        sy2  <= '0;
        filt <= '0;
        for (int j = 0; j < 2; j++) deb[j] <= '0;
      end else begin
        sy1 <= raw;
        sy2 <= sy1;
        for (int j = 0; j < 2; j++) begin
          if (sy2[j] != filt[j]) begin
            if (deb[j] == DW'(DEB_CYCLES - 1)) begin
              filt[j] <= sy2[j];
              deb[j]  <= '0;
            end else begin
              deb[j] <= deb[j] + DW'(1);
            end
          end else begin
            deb[j] <= '0;
          end
        end
      end
    end

    // exit states use the entry table with the two sensors swapped (q instead of p)
    always_comb begin
      st_d = st;
      unique case (st)
        REPOSO: begin
          case (p)
            2'b10:   st_d = E1;
            2'b01:   st_d = S1;
            2'b11:   st_d = INVALIDO;
            default: st_d = REPOSO;
          endcase
        end
        E1: begin
          case (p)
            2'b11:   st_d = E2;
            2'b00:   st_d = REPOSO;
            2'b10:   st_d = E1;
            default: st_d = INVALIDO;
          endcase
        end
        E2: begin
          case (p)
            2'b01:   st_d = E3;
            2'b10:   st_d = E1;
            2'b11:   st_d = E2;
            default: st_d = INVALIDO;
          endcase
        end
        E3: begin
          case (p)
            2'b00:   st_d = REPOSO;
            2'b11:   st_d = E2;
            2'b01:   st_d = E3;
            default: st_d = INVALIDO;
          endcase
        end
        S1: begin
          case (q)
            2'b11:   st_d = S2;
            2'b00:   st_d = REPOSO;
            2'b10:   st_d = S1;
            default: st_d = INVALIDO;
          endcase
        end
        S2: begin
          case (q)
            2'b01:   st_d = S3;
            2'b10:   st_d = S1;
            2'b11:   st_d = S2;
            default: st_d = INVALIDO;
          endcase
        end
        S3: begin
          case (q)
            2'b00:   st_d = REPOSO;
            2'b11:   st_d = S2;
            2'b01:   st_d = S3;
            default: st_d = INVALIDO;
          endcase
        end
        default: st_d = (p == 2'b00) ? REPOSO : INVALIDO;
      endcase
    end

    assign ent_c[i] = (st == E3) && (p == 2'b00);
    assign sal_c[i] = (st == S3) && (p == 2'b00);

    always_ff @(posedge clk) begin
      if (reset) begin
        st    <= REPOSO;
        ent_r <= 1'b0;
        sal_r <= 1'b0;
        err_r <= 1'b0;
      end else begin
        st    <= st_d;
        ent_r <= ent_c[i];
        sal_r <= sal_c[i];
        err_r <= (st_d == INVALIDO) && (st != INVALIDO);
      end
    end

    assign bus.entrada_p[i] = ent_r;
    assign bus.salida_p[i]  = sal_r;
    assign bus.error_seq[i] = err_r;
  end

  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   desb_q;
  logic                   desb_d;
  logic signed [SW-1:0]   delta;
  logic signed [SW-1:0]   suma;

  always_comb begin
    delta = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (ent_c[i]) delta = delta + UNO;
      if (sal_c[i]) delta = delta - UNO;
    end
    suma   = $signed({{(SW-CNT_W){1'b0}}, cnt_q}) + delta;
    cnt_d  = suma[CNT_W-1:0];
    desb_d = 1'b0;
    if (suma < 0) begin
      cnt_d  = '0;
      desb_d = 1'b1;
    end else if (suma > CAP_S) begin
      cnt_d  = CNT_W'(CAPACITY);
      desb_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      desb_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      desb_q <= desb_d;
    end
  end

  assign bus.cantidad = cnt_q;
  assign bus.desborde = desb_q;
  assign bus.lleno    = (cnt_q == CNT_W'(CAPACITY));
  assign bus.vacio    = (cnt_q == '0);

endmodule

// File: tb/tb_estacionamiento_multicanal.sv
// Directed bench for the multi-lane parking counter: vector table plus hand sequences for timing corners.
module tb_estacionamiento_multicanal;
  localparam int N   = 2;
  localparam int CAP = 7;
  localparam int CW  = 3;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  estacionamiento_multicanal_if #(.N_LANES(N), .CNT_W(CW)) bus ();

  estacionamiento_multicanal #(
    .N_LANES(N), .CAPACITY(CAP), .CNT_W(CW), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // pins are {lane1, lane0}, active-low; counts are pulses seen during the hold window
  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    int hold;
    int q;
    int e0, e1, s0, s1, r0, r1, d;
    int step;
  } vec_t;

  vec_t tv[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ce[N], cs[N], cr[N];
  int cd, mstep, prev_q;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] a, input logic [1:0] b, input int hold, input int q,
                     input int e0, input int e1, input int s0, input int s1,
                     input int r0, input int r1, input int d, input int step);
    vec_t v;
    v.a = a; v.b = b; v.hold = hold; v.q = q;
    v.e0 = e0; v.e1 = e1; v.s0 = s0; v.s1 = s1;
    v.r0 = r0; v.r1 = r1; v.d = d; v.step = step;
    tv.push_back(v);
  endtask

  task automatic run(input logic [1:0] av, input logic [1:0] bv, input int hold);
    int dq;
    bus.a = av;
    bus.b = bv;
    for (int i = 0; i < N; i++) begin ce[i] = 0; cs[i] = 0; cr[i] = 0; end
    cd = 0;
    mstep = 0;
    repeat (hold) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        ce[i] += int'(bus.entrada_p[i]);
        cs[i] += int'(bus.salida_p[i]);
        cr[i] += int'(bus.error_seq[i]);
      end
      cd += int'(bus.desborde);
      dq = int'(bus.cantidad) - prev_q;
      if (dq < 0) dq = -dq;
      if (dq > mstep) mstep = dq;
      prev_q = int'(bus.cantidad);
    end
  endtask

  task automatic no_pulses(input string nm, input int idx);
    chk({nm, " entrada"}, idx, ce[0] + ce[1], 0);
    chk({nm, " salida"},  idx, cs[0] + cs[1], 0);
    chk({nm, " error"},   idx, cr[0] + cr[1], 0);
  endtask

  initial begin
    int k_hit, q_hit, q_pre, d_hit;

    // reset and idle
    add(2'b11, 2'b11, 20, 0, 0,0,0,0, 0,0,0, 0);
    // lane 0 entry
    add(2'b10, 2'b11, 10, 0, 0,0,0,0, 0,0,0, 0);
    add(2'b10, 2'b10, 10, 0, 0,0,0,0, 0,0,0, 0);
    add(2'b11, 2'b10, 10, 0, 0,0,0,0, 0,0,0, 0);
    add(2'b11, 2'b11, 10, 1, 1,0,0,0, 0,0,0, 1);
    // lane 0 exit
    add(2'b11, 2'b10, 10, 1, 0,0,0,0, 0,0,0, 0);
    add(2'b10, 2'b10, 10, 1, 0,0,0,0, 0,0,0, 0);
    add(2'b10, 2'b11, 10, 1, 0,0,0,0, 0,0,0, 0);
    add(2'b11, 2'b11, 10, 0, 0,0,1,0, 0,0,0, 1);
    // lane 0 abort
    add(2'b10, 2'b11, 10, 0, 0,0,0,0, 0,0,0, 0);
    add(2'b11, 2'b11, 10, 0, 0,0,0,0, 0,0,0, 0);
    // lane 1 exit at empty: clamped at 0
    add(2'b11, 2'b01, 10, 0, 0,0,0,0, 0,0,0, 0);
    add(2'b01, 2'b01, 10, 0, 0,0,0,0, 0,0,0, 0);
    add(2'b01, 2'b11, 10, 0, 0,0,0,0, 0,0,0, 0);
    add(2'b11, 2'b11, 10, 0, 0,0,0,1, 0,0,1, 0);
    // both lanes enter together three times: 0->2->4->6
    for (int r = 1; r <= 3; r++) begin
      add(2'b00, 2'b11, 10, 2*r-2, 0,0,0,0, 0,0,0, 0);
      add(2'b00, 2'b00, 10, 2*r-2, 0,0,0,0, 0,0,0, 0);
      add(2'b11, 2'b00, 10, 2*r-2, 0,0,0,0, 0,0,0, 0);
      add(2'b11, 2'b11, 10, 2*r,   1,1,0,0, 0,0,0, 2);
    end
    // lane 0 entry to full
    add(2'b10, 2'b11, 10, 6, 0,0,0,0, 0,0,0, 0);
    add(2'b10, 2'b10, 10, 6, 0,0,0,0, 0,0,0, 0);
    add(2'b11, 2'b10, 10, 6, 0,0,0,0, 0,0,0, 0);
    add(2'b11, 2'b11, 10, 7, 1,0,0,0, 0,0,0, 1);
    // lane 1 entry while full: clamped at CAPACITY, pulse still issued
    add(2'b01, 2'b11, 10, 7, 0,0,0,0, 0,0,0, 0);
    add(2'b01, 2'b01, 10, 7, 0,0,0,0, 0,0,0, 0);
    add(2'b11, 2'b01, 10, 7, 0,0,0,0, 0,0,0, 0);
    add(2'b11, 2'b11, 10, 7, 0,1,0,0, 0,0,1, 0);
    // lane 0 entry and lane 1 exit on the same cycle while full: delta 0, no clamp
    add(2'b10, 2'b01, 10, 7, 0,0,0,0, 0,0,0, 0);
    add(2'b00, 2'b00, 10, 7, 0,0,0,0, 0,0,0, 0);
    add(2'b01, 2'b10, 10, 7, 0,0,0,0, 0,0,0, 0);
    add(2'b11, 2'b11, 10, 7, 1,0,0,1, 0,0,0, 0);
    // both lane 0 sensors at once: one error pulse, held until both release
    add(2'b10, 2'b10, 10, 7, 0,0,0,0, 1,0,0, 0);
    add(2'b10, 2'b10, 10, 7, 0,0,0,0, 0,0,0, 0);
    add(2'b11, 2'b10, 10, 7, 0,0,0,0, 0,0,0, 0);
    add(2'b11, 2'b11, 10, 7, 0,0,0,0, 0,0,0, 0);
    // lane 0 usable again: exit 7->6
    add(2'b11, 2'b10, 10, 7, 0,0,0,0, 0,0,0, 0);
    add(2'b10, 2'b10, 10, 7, 0,0,0,0, 0,0,0, 0);
    add(2'b10, 2'b11, 10, 7, 0,0,0,0, 0,0,0, 0);
    add(2'b11, 2'b11, 10, 6, 0,0,1,0, 0,0,0, 1);

    reset = 1'b1;
    bus.a = 2'b11;
    bus.b = 2'b11;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    prev_q = 0;

    foreach (tv[n]) begin
      run(tv[n].a, tv[n].b, tv[n].hold);
      chk("cantidad", n, int'(bus.cantidad), tv[n].q);
      chk("lleno",    n, int'(bus.lleno), (tv[n].q == CAP) ? 1 : 0);
      chk("vacio",    n, int'(bus.vacio), (tv[n].q == 0) ? 1 : 0);
      chk("entrada0", n, ce[0], tv[n].e0);
      chk("entrada1", n, ce[1], tv[n].e1);
      chk("salida0",  n, cs[0], tv[n].s0);
      chk("salida1",  n, cs[1], tv[n].s1);
      chk("error0",   n, cr[0], tv[n].r0);
      chk("error1",   n, cr[1], tv[n].r1);
      chk("desborde", n, cd, tv[n].d);
      chk("max_step", n, mstep, tv[n].step);
    end

    // 1-cycle and (DEB_CYCLES-1)-cycle glitches on a0 are filtered out
    bus.a = 2'b10;
    @(negedge clk);
    run(2'b11, 2'b11, 20);
    no_pulses("glitch1", 0);
    chk("glitch1 cantidad", 0, int'(bus.cantidad), 6);
    bus.a = 2'b10;
    repeat (DEB - 1) @(negedge clk);
    run(2'b11, 2'b11, 20);
    no_pulses("glitch3", 0);
    chk("glitch3 cantidad", 0, int'(bus.cantidad), 6);

    // exact event latency: release at a negedge, pulse and count seen on the 7th negedge
    run(2'b01, 2'b11, 10);
    run(2'b01, 2'b01, 10);
    run(2'b11, 2'b01, 10);
    bus.a = 2'b11;
    bus.b = 2'b11;
    k_hit = -1; q_hit = -1; q_pre = -1; d_hit = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 2 + DEB) q_pre = int'(bus.cantidad);
      if (bus.entrada_p[1] && k_hit < 0) begin
        k_hit = k;
        q_hit = int'(bus.cantidad);
        d_hit = int'(bus.desborde);
      end
    end
    chk("latency cycles", 0, k_hit, 3 + DEB);
    chk("latency count before", 0, q_pre, 6);
    chk("latency count with pulse", 0, q_hit, 7);
    chk("latency desborde", 0, d_hit, 0);
    chk("latency lleno", 0, int'(bus.lleno), 1);

    // reset while lane 0 sits in E2
    prev_q = 7;
    run(2'b10, 2'b11, 10);
    run(2'b10, 2'b10, 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset cantidad", 0, int'(bus.cantidad), 0);
    chk("reset vacio", 0, int'(bus.vacio), 1);
    chk("reset lleno", 0, int'(bus.lleno), 0);
    chk("reset pulses", 0, int'(bus.entrada_p) + int'(bus.salida_p) + int'(bus.error_seq)
                           + int'(bus.desborde), 0);
    prev_q = 0;
    // sensors still blocked: from REPOSO both levels rise together, so one error pulse
    run(2'b10, 2'b10, 10);
    chk("post-reset error0", 0, cr[0], 1);
    chk("post-reset entrada", 0, ce[0] + ce[1], 0);
    run(2'b11, 2'b11, 10);
    no_pulses("post-reset release", 0);
    chk("post-reset cantidad", 0, int'(bus.cantidad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
